mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline register between the memory stage and the register-file write-back port of the 32-bit RISC core.
- Captures the function-unit result, the memory read data (Data_out from the data memory), the link PC and the write-back control fields.
- Selects the write-back value onto BUS_D, suppresses writes to R0, raises forwarding hits for the decode stage, and keeps a retired-instruction counter.

Parameters:
DATA_W, 32, width of the data path and of BUS_D
RA_W, 5, register-file address width
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  system clock, rising edge active
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
stall  input  1  hold all stage registers
flush  input  1  load a bubble into the stage
in_valid  input  1  memory stage holds a real instruction
RW_in  input  1  register-write enable from the memory stage
DA_in  input  RA_W  destination register address
MD_in  input  2  write-back select: 00 F_in, 01 Data_out, 10 PC_in+1, 11 reserved
F_in  input  DATA_W  function-unit result
Data_out  input  DATA_W  data memory read data
PC_in  input  DATA_W  PC of the instruction in the memory stage
AA  input  RA_W  decode-stage read address A
BA  input  RA_W  decode-stage read address B
wb_valid  output  1  registered valid
RW_out  output  1  registered register-write enable to the register file
DA_out  output  RA_W  registered destination address
BUS_D  output  DATA_W  registered write-back data
fwd_A  output  1  forward BUS_D onto bus A
fwd_B  output  1  forward BUS_D onto bus B
retired  output  CNT_W  count of valid instructions captured

Behaviour:
Reset:
- rst=0 asynchronously clears wb_valid, RW_out, DA_out, BUS_D and retired to 0.
- Reset may be asserted mid-stall or mid-flush; it overrides everything.
- First capture occurs on the first rising edge after rst returns to 1.

Capture rules (rising edge of clk, rst=1), priority flush > stall > load:
- flush=1: wb_valid<=0 and RW_out<=0. DA_out and BUS_D hold their values. retired holds. Flush wins even when stall=1.
- stall=1 and flush=0: all registers hold. retired holds.
- Load (stall=0, flush=0):
  - wb_valid<=in_valid.
  - RW_out<=in_valid & RW_in & (DA_in!=0). R0 is never written.
  - DA_out<=DA_in.
  - BUS_D<=sel(MD_in), where sel is 00 F_in, 01 Data_out, 10 PC_in+1 (modulo 2^DATA_W, so 0xFFFFFFFF+1 = 0), and 11 gives 0. On MD_in=11, RW_out is forced to 0.
  - retired increments by 1 when in_valid=1. It wraps from all-ones to 0.

Latency:
- One cycle from the inputs to BUS_D, RW_out and DA_out.
- Data_out is sampled at the same edge the memory performs its write, so it is the pre-write read value.

Forwarding (combinational from registered outputs only):
- fwd_A = wb_valid & RW_out & (DA_out==AA) & (AA!=0). fwd_B is the same with BA.
- Both fwd_A and fwd_B may be 1 at the same time.
- Forwarding stays valid through a stall because the registers hold.

No other state exists. No output depends combinationally on F_in, Data_out, PC_in or MD_in.

Test Plan:
1. Reset: rst=0 with all inputs nonzero -> all outputs 0 immediately, before any clk edge. Release rst; first edge with in_valid=1, MD_in=00, F_in=0x12345678, DA_in=3, RW_in=1 -> BUS_D=0x12345678, RW_out=1, DA_out=3, retired=1.
2. Mux and wrap: MD_in=01, Data_out=0xDEADBEEF -> BUS_D=0xDEADBEEF. MD_in=10, PC_in=0xFFFFFFFF -> BUS_D=0. MD_in=11 -> BUS_D=0 and RW_out=0.
3. R0 guard: DA_in=0, RW_in=1, in_valid=1 -> RW_out=0, wb_valid=1, retired increments. Then AA=0 -> fwd_A=0.
4. Stall vs flush: load DA=7, BUS_D=0x55. Hold stall=1 for 3 cycles with new inputs -> outputs unchanged and fwd_A=1 for AA=7. Then stall=1 and flush=1 together -> wb_valid=0, RW_out=0, fwd_A=0, retired unchanged.
5. Forwarding: DA_out=9 written; AA=9, BA=9 -> fwd_A=1 and fwd_B=1. BA=10 -> fwd_B=0.
6. Counter wrap and async reset: preload retired to 0xFFFFFFFF (force or via the CNT_W=4 variant at 0xF) and capture a valid instruction -> retired=0. Assert rst mid-cycle during stall -> retired=0 without waiting for a clk edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Pipeline register between the memory stage and the register-file write-back
// port of the 32-bit RISC core. It captures the function-unit result, the data
// memory read data, the link PC and the write-back control fields. It selects
// the write-back value onto BUS_D, suppresses writes to R0, raises forwarding
// hits for the decode stage and counts retired instructions.
//
// Ports:
//   clk       system clock, rising edge active
//   rst       asynchronous active-low reset
//   stall     hold all stage registers
//   flush     load a bubble (clears wb_valid / RW_out, data fields hold)
//   in_valid  memory stage holds a real instruction
//   RW_in     register-write enable from the memory stage
//   DA_in     destination register address
//   MD_in     write-back select: 00 F_in, 01 Data_out, 10 PC_in+1, 11 reserved
//   F_in      function-unit result
//   Data_out  data memory read data (pre-write value at this edge)
//   PC_in     PC of the instruction in the memory stage
//   AA, BA    decode-stage read addresses A and B
//   wb_valid  registered valid
//   RW_out    registered register-write enable
//   DA_out    registered destination address
//   BUS_D     registered write-back data
//   fwd_A     forward BUS_D onto bus A
//   fwd_B     forward BUS_D onto bus B
//   retired   count of valid instructions captured (wraps)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              RW_in,
   input  logic [RA_W-1:0]   DA_in,
   input  logic [1:0]        MD_in,
   input  logic [DATA_W-1:0] F_in,
   input  logic [DATA_W-1:0] Data_out,
   input  logic [DATA_W-1:0] PC_in,
   input  logic [RA_W-1:0]   AA,
   input  logic [RA_W-1:0]   BA,
   output logic              wb_valid,
   output logic              RW_out,
   output logic [RA_W-1:0]   DA_out,
   output logic [DATA_W-1:0] BUS_D,
   output logic              fwd_A,
   output logic              fwd_B,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {
      MD_FU   = 2'b00,
      MD_MEM  = 2'b01,
      MD_LINK = 2'b10,
      MD_RSVD = 2'b11
   } md_sel_t;

   logic [DATA_W-1:0] wb_data;
   logic              wb_write;

   // Next-state write-back value and write enable for a normal load.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave it unassigned, which would infer a latch.
      wb_data  = '0;
      wb_write = in_valid & RW_in & (DA_in != '0);
      case (md_sel_t'(MD_in))
         MD_FU:   wb_data = F_in;
         MD_MEM:  wb_data = Data_out;
         MD_LINK: wb_data = PC_in + DATA_W'(1);   // link address, wraps modulo 2^DATA_W
         default: wb_write = 1'b0;                // reserved select: no data, no write
      endcase
   end

   // Priority: reset > flush > stall > load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: non-blocking assignments for all registered state, so every
         // register samples the pre-edge values regardless of statement order.
         wb_valid <= 1'b0;
         RW_out   <= 1'b0;
         DA_out   <= '0;
         BUS_D    <= '0;
         retired  <= '0;
      end else if (flush) begin
         // Bubble: only the control bits clear; data fields and counter hold.
         wb_valid <= 1'b0;
         RW_out   <= 1'b0;
      end else if (!stall) begin
         wb_valid <= in_valid;
         RW_out   <= wb_write;
         DA_out   <= DA_in;
         BUS_D    <= wb_data;
         retired  <= retired + CNT_W'(in_valid);
      end
   end

   // Forwarding is derived only from registered state, so it stays stable
   // through a stall. R0 never forwards.
   assign fwd_A = wb_valid & RW_out & (DA_out == AA) & (AA != '0);
   assign fwd_B = wb_valid & RW_out & (DA_out == BA) & (BA != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, in_valid, RW_in;
   logic [4:0]  DA_in, AA, BA;
   logic [1:0]  MD_in;
   logic [31:0] F_in, Data_out, PC_in;

   logic        wb_valid, RW_out, fwd_A, fwd_B;
   logic [4:0]  DA_out;
   logic [31:0] BUS_D, retired;

   // Narrow-counter variant sharing the same stimulus, used for the wrap test.
   logic        s_wb_valid, s_RW_out, s_fwd_A, s_fwd_B;
   logic [4:0]  s_DA_out;
   logic [31:0] s_BUS_D;
   logic [3:0]  s_retired;

   int total = 0;
   int bad   = 0;
   int model_cnt = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .RW_in(RW_in), .DA_in(DA_in), .MD_in(MD_in), .F_in(F_in),
      .Data_out(Data_out), .PC_in(PC_in), .AA(AA), .BA(BA),
      .wb_valid(wb_valid), .RW_out(RW_out), .DA_out(DA_out), .BUS_D(BUS_D),
      .fwd_A(fwd_A), .fwd_B(fwd_B), .retired(retired)
   );

   mem_wb_stage #(.DATA_W(32), .RA_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .RW_in(RW_in), .DA_in(DA_in), .MD_in(MD_in), .F_in(F_in),
      .Data_out(Data_out), .PC_in(PC_in), .AA(AA), .BA(BA),
      .wb_valid(s_wb_valid), .RW_out(s_RW_out), .DA_out(s_DA_out), .BUS_D(s_BUS_D),
      .fwd_A(s_fwd_A), .fwd_B(s_fwd_B), .retired(s_retired)
   );

   typedef struct {
      logic        valid;
      logic        rw;
      logic [4:0]  da;
      logic [1:0]  md;
      logic [31:0] f;
      logic [31:0] dout;
      logic [31:0] pc;
      logic [31:0] exp_bus;
      logic        exp_rw;
   } vec_t;

   typedef struct {
      logic        valid;
      logic        rw;
      logic [4:0]  da;
      logic [31:0] bus;
      logic [31:0] ret;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one load at the negedge and push its expected result.
   task automatic drive(input vec_t v);
      @(negedge clk);
      stall    = 1'b0;
      flush    = 1'b0;
      in_valid = v.valid;
      RW_in    = v.rw;
      DA_in    = v.da;
      MD_in    = v.md;
      F_in     = v.f;
      Data_out = v.dout;
      PC_in    = v.pc;
      if (v.valid) model_cnt++;
      sb.push_back('{valid: v.valid, rw: v.exp_rw, da: v.da, bus: v.exp_bus,
                     ret: 32'(model_cnt)});
   endtask

   // After the capturing edge, pop the expected record and compare.
   task automatic sample(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_valid"},   32'(wb_valid), 32'(e.valid));
         check({tag, "_rw"},      32'(RW_out),   32'(e.rw));
         check({tag, "_da"},      32'(DA_out),   32'(e.da));
         check({tag, "_bus"},     BUS_D,         e.bus);
         check({tag, "_retired"}, retired,       e.ret);
         check({tag, "_ret4"},    32'(s_retired), e.ret & 32'hF);
      end
   endtask

   task automatic load(input logic valid, input logic rw, input logic [4:0] da,
                       input logic [31:0] f, input string tag);
      vec_t v;
      v = '{valid: valid, rw: rw, da: da, md: 2'b00, f: f, dout: 32'h0,
            pc: 32'h0, exp_bus: f, exp_rw: valid & rw & (da != 0)};
      drive(v);
      sample(tag);
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b1, 5'd3, 2'b00, 32'h12345678, 32'h0, 32'h0, 32'h12345678, 1'b1};
      vecs[1] = '{1'b1, 1'b1, 5'd4, 2'b01, 32'h11111111, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 5'd5, 2'b10, 32'h22222222, 32'h33333333, 32'hFFFFFFFF, 32'h0, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 5'd6, 2'b11, 32'h44444444, 32'h55555555, 32'h66666666, 32'h0, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 5'd0, 2'b00, 32'h0000AAAA, 32'h0, 32'h0, 32'h0000AAAA, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 5'd8, 2'b00, 32'h00000077, 32'h0, 32'h0, 32'h00000077, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 5'd2, 2'b10, 32'h0, 32'h0, 32'h00000100, 32'h00000101, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 5'd9, 2'b01, 32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 1'b0};

      // Reset with every input nonzero: outputs must clear before any edge.
      rst = 1'b0;
      stall = 1'b1; flush = 1'b1; in_valid = 1'b1; RW_in = 1'b1;
      DA_in = 5'd7; MD_in = 2'b01; F_in = 32'hFFFF0000; Data_out = 32'h1;
      PC_in = 32'h10; AA = 5'd7; BA = 5'd7;
      #3;
      check("rst_valid",   32'(wb_valid), 32'd0);
      check("rst_rw",      32'(RW_out),   32'd0);
      check("rst_da",      32'(DA_out),   32'd0);
      check("rst_bus",     BUS_D,         32'd0);
      check("rst_retired", retired,       32'd0);
      check("rst_fwd_A",   32'(fwd_A),    32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Table-driven loads: mux select, link wrap, reserved select, R0 guard.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i]);
         sample($sformatf("vec%0d", i));
      end

      // R0 written with RW_in=1: no write, so no forward even for AA=0.
      load(1'b1, 1'b1, 5'd0, 32'h0000BBBB, "r0");
      AA = 5'd0; BA = 5'd0;
      #1;
      check("r0_fwd_A", 32'(fwd_A), 32'd0);
      check("r0_fwd_B", 32'(fwd_B), 32'd0);

      // Stall for three cycles with new inputs: everything holds.
      load(1'b1, 1'b1, 5'd7, 32'h00000055, "pre_stall");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         stall = 1'b1; flush = 1'b0; in_valid = 1'b1; RW_in = 1'b1;
         DA_in = 5'd12; MD_in = 2'b00; F_in = 32'h99999999; AA = 5'd7;
         @(posedge clk);
         #1;
         check($sformatf("stall%0d_bus", c), BUS_D, 32'h00000055);
         check($sformatf("stall%0d_da", c), 32'(DA_out), 32'd7);
         check($sformatf("stall%0d_retired", c), retired, 32'(model_cnt));
         check($sformatf("stall%0d_fwd_A", c), 32'(fwd_A), 32'd1);
      end

      // Flush wins over stall: control clears, data and counter hold.
      @(negedge clk);
      stall = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      check("flush_valid",   32'(wb_valid), 32'd0);
      check("flush_rw",      32'(RW_out),   32'd0);
      check("flush_fwd_A",   32'(fwd_A),    32'd0);
      check("flush_bus",     BUS_D,         32'h00000055);
      check("flush_da",      32'(DA_out),   32'd7);
      check("flush_retired", retired,       32'(model_cnt));

      // Dual forwarding hit, then a miss on B.
      load(1'b1, 1'b1, 5'd9, 32'h00000099, "fwd");
      AA = 5'd9; BA = 5'd9;
      #1;
      check("fwd_A_hit", 32'(fwd_A), 32'd1);
      check("fwd_B_hit", 32'(fwd_B), 32'd1);
      BA = 5'd10;
      #1;
      check("fwd_B_miss", 32'(fwd_B), 32'd0);
      check("fwd_A_keep", 32'(fwd_A), 32'd1);

      // Narrow counter: advance to all-ones, then one more capture wraps it.
      for (int k = 0; k < 16 && (model_cnt % 16) != 15; k++)
         load(1'b1, 1'b1, 5'd1, 32'(k), "pre_wrap");
      check("ret4_at_max", 32'(s_retired), 32'hF);
      load(1'b1, 1'b1, 5'd1, 32'h0, "wrap");
      check("ret4_wrapped", 32'(s_retired), 32'h0);

      // Asynchronous reset mid-cycle during a stall.
      @(negedge clk);
      stall = 1'b1; flush = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("arst_retired", retired,       32'd0);
      check("arst_ret4",    32'(s_retired), 32'd0);
      check("arst_valid",   32'(wb_valid),  32'd0);
      check("arst_bus",     BUS_D,          32'd0);
      check("arst_rw",      32'(RW_out),    32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
